// File: rtl/mbus_memory.sv
// mbus_memory: memory-side responder for the internal memory bus.
// Answers quadword read, write and read-pause-write cycles from a
// synchronous 2^ADDR_BITS x 36 word array. Requests whose address lies
// outside the implemented array are never acknowledged.
// MBUS bit numbering is mapped onto descending vectors:
//   adr_i[21] is MBUS adr[14] ... adr_i[1:0] is MBUS adr[34:35]
//   rq_i[3]   is MBUS rq[0]   ... rq_i[0]   is MBUS rq[3]
// Optional feature: define MBUS_MEM_PARITY_CHECK_EN to check write parity
// (bad words are dropped and the sticky error_o is set).
module mbus_memory #(
  parameter int ADDR_BITS    = 14,
  parameter int READ_LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        memReset_i,
  input  logic        startA_i,
  input  logic        startB_i,
  input  logic [21:0] adr_i,
  input  logic        rdRq_i,
  input  logic        wrRq_i,
  input  logic [3:0]  rq_i,
  input  logic [35:0] dOut_i,
  input  logic        parOut_i,
  input  logic        validOutA_i,
  input  logic        validOutB_i,
  input  logic        diag_i,
  input  logic        adrHold_i,
  input  logic        adrPar_i,
  input  logic        adrParErr_i,
  output logic        acknA_o,
  output logic        acknB_o,
  output logic [35:0] dIn_o,
  output logic        parIn_o,
  output logic        validInA_o,
  output logic        validInB_o,
  output logic        error_o
);

  localparam int WORDS = 1 << ADDR_BITS;

  typedef enum logic [2:0] {S_IDLE, S_ACK, S_LAT, S_RD, S_WR} state_t;

  state_t                 state_q;
  logic                   port_b_q;
  logic [ADDR_BITS-1:0]   base_q;
  logic                   rd_q, wr_q;
  logic [3:0]             rq_q;     // enable mask indexed by quadword offset
  logic [3:0]             pend_q;   // slots not yet served in this phase
  logic [1:0]             off_q;    // next offset to consider (wrap order)
  logic [15:0]            cnt_q;
  logic                   acknA_q, acknB_q, validInA_q, validInB_q;
  logic [35:0]            dIn_q;
  logic                   parIn_q, error_q;
  logic [35:0]            mem_q [WORDS];

  logic [3:0]             rq_vec;
  logic                   in_range;
  logic [2:0]             nxt;
  logic                   nxt_found;
  logic [1:0]             nxt_off;
  logic [3:0]             pend_clr;
  logic [ADDR_BITS-1:0]   slot_addr;
  logic [35:0]            rd_word;
  logic                   vout, par_ok, wr_beat, mem_we, emit;
  logic                   unused_ok;

  // First pending slot at or after the current offset, in wrap order.
  function automatic logic [2:0] next_slot(input logic [3:0] pend, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] o;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      o = start + 2'(k);
      if (pend[o]) res = {1'b1, o};
    end
    return res;
  endfunction

  assign rq_vec    = {rq_i[0], rq_i[1], rq_i[2], rq_i[3]};
  assign in_range  = (adr_i >> ADDR_BITS) == 22'd0;
  assign nxt       = next_slot(pend_q, off_q);
  assign nxt_found = nxt[2];
  assign nxt_off   = nxt[1:0];
  assign pend_clr  = pend_q & ~(4'b0001 << nxt_off);
  assign slot_addr = (base_q & ~ADDR_BITS'(3)) | ADDR_BITS'(nxt_off);
  assign rd_word   = mem_q[slot_addr];
  assign vout      = port_b_q ? validOutB_i : validOutA_i;
  assign wr_beat   = (state_q == S_WR) && vout && !memReset_i;
  assign mem_we    = wr_beat && par_ok;

  // A read beat is launched from ACK (latency 1), the last LAT cycle, or RD.
  assign emit = ((state_q == S_ACK) && (READ_LATENCY == 1) && rd_q && nxt_found) ||
                ((state_q == S_LAT) && (cnt_q == 16'd0)) ||
                ((state_q == S_RD) && nxt_found);

`ifdef MBUS_MEM_PARITY_CHECK_EN
  assign par_ok    = (parOut_i == ~^dOut_i);
  assign unused_ok = ^{diag_i, adrHold_i, adrPar_i, adrParErr_i};
`else
  assign par_ok    = 1'b1;
  assign unused_ok = ^{diag_i, adrHold_i, adrPar_i, adrParErr_i, parOut_i};
`endif

  // Cycle sequencer with registered bus outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;   port_b_q <= 1'b0;   base_q <= '0;
      rd_q <= 1'b0;        wr_q <= 1'b0;       rq_q <= 4'b0;
      pend_q <= 4'b0;      off_q <= 2'b0;      cnt_q <= 16'd0;
      acknA_q <= 1'b0;     acknB_q <= 1'b0;
      validInA_q <= 1'b0;  validInB_q <= 1'b0;
      dIn_q <= '0;         parIn_q <= 1'b0;    error_q <= 1'b0;
    end else if (memReset_i) begin
      state_q <= S_IDLE;
      acknA_q <= 1'b0;     acknB_q <= 1'b0;
      validInA_q <= 1'b0;  validInB_q <= 1'b0;
      dIn_q <= '0;         parIn_q <= 1'b0;    error_q <= 1'b0;
    end else begin
      acknA_q    <= 1'b0;
      acknB_q    <= 1'b0;
      validInA_q <= emit & ~port_b_q;
      validInB_q <= emit & port_b_q;
      dIn_q      <= emit ? rd_word : '0;
      parIn_q    <= emit & ~^rd_word;
      error_q    <= error_q | (wr_beat & ~par_ok);
      if (emit || wr_beat) begin
        pend_q <= pend_clr;
        off_q  <= nxt_off + 2'd1;
      end
      case (state_q)
        S_IDLE: begin
          if ((startA_i || startB_i) && in_range) begin
            port_b_q <= !startA_i;
            base_q   <= adr_i[ADDR_BITS-1:0];
            rd_q     <= rdRq_i;
            wr_q     <= wrRq_i;
            rq_q     <= rq_vec;
            pend_q   <= rq_vec;
            off_q    <= adr_i[1:0];
            acknA_q  <= startA_i;
            acknB_q  <= !startA_i;
            state_q  <= S_ACK;
          end
        end
        S_ACK: begin
          if (!nxt_found || !(rd_q || wr_q)) state_q <= S_IDLE;
          else if (rd_q) begin
            if (READ_LATENCY == 1) state_q <= S_RD;
            else begin
              cnt_q   <= 16'(READ_LATENCY - 2);
              state_q <= S_LAT;
            end
          end else state_q <= S_WR;
        end
        S_LAT: begin
          if (cnt_q == 16'd0) state_q <= S_RD;
          else cnt_q <= cnt_q - 16'd1;
        end
        S_RD: begin
          if (!nxt_found) begin
            if (wr_q) begin
              pend_q  <= rq_q;
              off_q   <= base_q[1:0];
              state_q <= S_WR;
            end else state_q <= S_IDLE;
          end
        end
        S_WR: begin
          if (wr_beat && (pend_clr == 4'b0)) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Word array: written at the edge that samples validOut.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[slot_addr] <= dOut_i;
  end

  assign acknA_o    = acknA_q;
  assign acknB_o    = acknB_q;
  assign validInA_o = validInA_q;
  assign validInB_o = validInB_q;
  assign dIn_o      = dIn_q;
  assign parIn_o    = parIn_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_mbus_memory.sv
// Self-checking bench for mbus_memory: directed cycles plus randomized
// transactions checked against a word-level memory model.
module tb_mbus_memory;
  localparam int RL = 4;
`ifdef MBUS_MEM_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, memReset, startA, startB, rdRq, wrRq;
  logic [21:0] adr;
  logic [3:0]  rq;
  logic [35:0] dOut, dIn;
  logic        parOut, validOutA, validOutB, diag, adrHold, adrPar, adrParErr;
  logic        acknA, acknB, parIn, validInA, validInB, error;

  int errs = 0;
  int checks = 0;
  logic [35:0] mdl [int];
  logic [35:0] wq [$];
  int max_gap = 1;
  bit exp_err = 1'b0;
  bit bad_next = 1'b0;

  mbus_memory #(.ADDR_BITS(14), .READ_LATENCY(RL)) dut (
    .clk_i(clk), .reset_i(reset), .memReset_i(memReset),
    .startA_i(startA), .startB_i(startB), .adr_i(adr),
    .rdRq_i(rdRq), .wrRq_i(wrRq), .rq_i(rq),
    .dOut_i(dOut), .parOut_i(parOut),
    .validOutA_i(validOutA), .validOutB_i(validOutB),
    .diag_i(diag), .adrHold_i(adrHold), .adrPar_i(adrPar), .adrParErr_i(adrParErr),
    .acknA_o(acknA), .acknB_o(acknB), .dIn_o(dIn), .parIn_o(parIn),
    .validInA_o(validInA), .validInB_o(validInB), .error_o(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] rnd36();
    return {4'($urandom), $urandom()};
  endfunction

  // One complete bus cycle; MBUS rq[i] (offset i) is bit 3-i of r.
  task automatic txn(input bit pb, input int a, input logic [3:0] r, input bit rd, input bit wr);
    int slots[$];
    logic [35:0] d;
    logic [35:0] w;
    for (int k = 0; k < 4; k++) begin
      int o;
      o = (a + k) % 4;
      if (r[3-o]) slots.push_back((a / 4) * 4 + o);
    end
    startA = !pb; startB = pb; adr = 22'(a); rdRq = rd; wrRq = wr; rq = r;
    validOutA = 1'b0; validOutB = 1'b0;
    tick();
    chk("ackn", {acknA, acknB}, pb ? 2'b01 : 2'b10);
    startA = 1'b0; startB = 1'b0;
    if (rd && slots.size() > 0) begin
      for (int i = 0; i < RL - 1; i++) begin
        tick();
        chk("lat_quiet", {validInA, validInB}, 2'b00);
      end
      foreach (slots[i]) begin
        tick();
        d = mdl[slots[i]];
        chk("rd_valid", {validInA, validInB}, pb ? 2'b01 : 2'b10);
        chk("rd_data", dIn, d);
        chk("rd_par", parIn, ~^d);
      end
    end
    if (wr && slots.size() > 0) begin
      tick();
      foreach (slots[i]) begin
        repeat ($urandom_range(0, max_gap)) begin
          if (pb) validOutA = 1'($urandom_range(0, 1));
          else    validOutB = 1'($urandom_range(0, 1));
          tick();
        end
        validOutA = 1'b0; validOutB = 1'b0;
        if (wq.size() > 0) w = wq.pop_front();
        else w = rnd36();
        dOut = w;
        parOut = (~^w) ^ bad_next;
        if (pb) validOutB = 1'b1;
        else    validOutA = 1'b1;
        tick();
        validOutA = 1'b0; validOutB = 1'b0;
        if (bad_next && PAR_EN) exp_err = 1'b1;
        else mdl[slots[i]] = w;
        bad_next = 1'b0;
      end
    end
    tick();
    chk("idle_ackn", {acknA, acknB}, 2'b00);
    chk("idle_valid", {validInA, validInB}, 2'b00);
    chk("idle_dIn", {parIn, dIn}, 37'd0);
    chk("error", error, exp_err);
  endtask

  initial begin
    int cnt;
    logic [35:0] w;
    reset = 1'b1; memReset = 1'b0; startA = 1'b0; startB = 1'b0;
    adr = '0; rdRq = 1'b0; wrRq = 1'b0; rq = 4'b0; dOut = '0; parOut = 1'b0;
    validOutA = 1'b0; validOutB = 1'b0;
    diag = 1'b0; adrHold = 1'b0; adrPar = 1'b0; adrParErr = 1'b0;

    // reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", {acknA, acknB, validInA, validInB, error, parIn, dIn}, 42'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_outs", {acknA, acknB, validInA, validInB, error, parIn, dIn}, 42'd0);

    // quadword write 1..4 at 0x10, then wrapped partial read on port B
    wq = '{36'd1, 36'd2, 36'd3, 36'd4};
    txn(1'b0, 'h10, 4'b1111, 1'b0, 1'b1);
    chk("plan_mem10", mdl['h10], 36'd1);
    txn(1'b1, 'h12, 4'b1011, 1'b1, 1'b0);

    // fill the working region
    for (int q = 0; q < 16; q++) txn(1'($urandom_range(0, 1)), q * 4, 4'b1111, 1'b0, 1'b1);

    // simultaneous starts: A first, B once A's cycle is back in IDLE
    startA = 1'b1; startB = 1'b1; adr = 22'h28; rdRq = 1'b0; wrRq = 1'b1; rq = 4'b0001;
    w = rnd36(); dOut = w; parOut = ~^w; validOutA = 1'b1; validOutB = 1'b0;
    tick();
    chk("both_ack_a", {acknA, acknB}, 2'b10);
    startA = 1'b0;
    tick();
    chk("both_ack_wr", {acknA, acknB}, 2'b00);
    tick();
    chk("both_idle", {acknA, acknB}, 2'b00);
    validOutA = 1'b0;
    tick();
    chk("both_ack_b", {acknA, acknB}, 2'b01);
    startB = 1'b0;
    w = rnd36(); dOut = w; parOut = ~^w; validOutB = 1'b1;
    tick();
    tick();
    validOutB = 1'b0;
    mdl['h2B] = w;
    txn(1'b0, 'h28, 4'b0001, 1'b1, 1'b0);

    // back-to-back: one-word write with validOut already high takes 3 cycles
    startA = 1'b1; adr = 22'h18; rdRq = 1'b0; wrRq = 1'b1; rq = 4'b0100;
    w = rnd36(); dOut = w; parOut = ~^w; validOutA = 1'b1;
    tick();
    chk("min3_ack", {acknA, acknB}, 2'b10);
    startA = 1'b0;
    tick();
    tick();
    validOutA = 1'b0;
    mdl['h19] = w;
    txn(1'b1, 'h18, 4'b0100, 1'b1, 1'b0);

    // out-of-range addresses are never acknowledged
    startA = 1'b1; rdRq = 1'b1; wrRq = 1'b0; rq = 4'b1111;
    adr = 22'h200000;
    cnt = 0;
    repeat (20) begin tick(); cnt += int'(acknA | acknB); end
    chk("oor_msb", cnt, 0);
    adr = 22'h004000;
    cnt = 0;
    repeat (20) begin tick(); cnt += int'(acknA | acknB); end
    chk("oor_lsb", cnt, 0);
    startA = 1'b0;
    tick();
    // highest implemented quadword
    txn(1'b0, 'h3FFC, 4'b1111, 1'b0, 1'b1);
    txn(1'b1, 'h3FFE, 4'b1111, 1'b1, 1'b0);

    // read-pause-write
    wq = '{36'd7};
    txn(1'b0, 'h20, 4'b1000, 1'b0, 1'b1);
    wq = '{36'd9};
    txn(1'b1, 'h20, 4'b1000, 1'b1, 1'b1);
    txn(1'b0, 'h20, 4'b1000, 1'b1, 1'b0);
    chk("rpw_model", mdl['h20], 36'd9);

    // bad write parity
    bad_next = 1'b1;
    txn(1'b0, 'h30, 4'b0100, 1'b0, 1'b1);
    txn(1'b0, 'h30, 4'b0100, 1'b1, 1'b0);

    // memReset in the middle of the read latency
    startA = 1'b1; adr = 22'h10; rdRq = 1'b1; wrRq = 1'b0; rq = 4'b1111;
    tick();
    chk("mrst_ack", {acknA, acknB}, 2'b10);
    startA = 1'b0;
    tick();
    memReset = 1'b1;
    tick();
    memReset = 1'b0;
    exp_err = 1'b0;
    chk("mrst_err", error, 1'b0);
    cnt = 0;
    repeat (RL + 4) begin tick(); cnt += int'(validInA | validInB); end
    chk("mrst_novalid", cnt, 0);
    txn(1'b1, 'h10, 4'b1111, 1'b1, 1'b0);

    // randomized cycles over the filled region
    max_gap = 2;
    for (int n = 0; n < 40; n++)
      txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 4'($urandom),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mbus_memory.md
# mbus_memory

Memory-side responder for the internal memory bus (`iMBUS.memory` modport). It sits where the SBUS memory controllers sat behind the MT01 translator and answers MBOX quadword read, write and read-pause-write cycles from a synchronous word array. It acknowledges requests, sequences up to four words per cycle in wrap order, generates read parity and optionally checks write parity. Out-of-range addresses are never acknowledged, so the MBOX sees nonexistent memory.

## Interface
Parameters:
- `ADDR_BITS`, 14: word-address width implemented, 2..22. Backing store is 2^ADDR_BITS × 36 bits.
- `READ_LATENCY`, 4: cycles from the `ackn` pulse to the first `validIn`. Must be ≥1.

Ports (signals named as in the `iMBUS.memory` modport):
- `clk` in 1: sole clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `memReset` in 1: synchronous soft reset; same effect as `reset` except array contents are kept.
- `startA`, `startB` in 1 each: request strobes, level-held by the MBOX until the matching `ackn`.
- `adr` in [14:35]: word address; `adr[34:35]` selects the first word of the quadword.
- `rdRq`, `wrRq` in 1 each: cycle type. Read, write, or both (read-pause-write, RPW).
- `rq` in [0:3]: word-enable mask, where `rq[i]` enables quadword offset i.
- `dOut`, `parOut` in 36/1: write data and its odd parity.
- `validOutA`, `validOutB` in 1 each: MBOX write-data valid for the port being served.
- `acknA`, `acknB` out 1 each: one-cycle acknowledge.
- `dIn`, `parIn` out 36/1: read data and its odd parity.
- `validInA`, `validInB` out 1 each: read-data valid, one cycle per word.
- `error` out 1: sticky parity error.
- `diag`, `adrHold`, `adrPar`, `adrParErr` in: accepted, ignored.

## Operation
- States: IDLE, ACK, LAT, RD, WR.
- IDLE:
  - Samples the start strobes; `startA` wins if both are high.
  - If the upper address bits `adr[14:35-ADDR_BITS]` are nonzero, the request is ignored: no ack, stay in IDLE.
  - Otherwise latches port, `adr`, `rdRq`, `wrRq` and `rq` → ACK.
- ACK: `acknX` high for exactly one cycle.
  - If `rq`=0, or neither `rdRq` nor `wrRq` is set → IDLE.
  - Else if `rdRq` → LAT.
  - Else → WR.
- LAT: wait READ_LATENCY−1 cycles → RD.
- RD: steps a 2-bit offset starting at the latched `adr[34:35]`, incrementing mod 4 over four slots.
  - Slots with `rq` bit 0 are skipped with no beat and no cycle spent.
  - Each enabled slot drives `dIn` = array[{index, offset}], `parIn` = ~^dIn, and `validInX` for one cycle.
  - After the last enabled slot: → WR if `wrRq`, else → IDLE.
- WR: same slot order.
  - For each enabled slot, waits indefinitely for `validOutX` of the served port.
  - On that cycle, captures `dOut` and writes the array at the same edge.
  - `validOut` on the other port is ignored.
  - After the last enabled slot → IDLE.
- The MBOX must drop `start` in the cycle after `ackn`. Starts arriving while not in IDLE are not acknowledged.
- `dIn`/`parIn` are 0 outside read beats.
- `memReset` or `reset` in any state → IDLE immediately. A partly written quadword keeps the words already written.

## Timing
- Reset values: `acknA`/`acknB`/`validInA`/`validInB`/`error` = 0, `dIn` = 0, `parIn` = 0.
- Start sampled at edge T → `ackn` high in cycle T+1 → first `validIn` in cycle T+1+READ_LATENCY. Enabled words follow back-to-back, one per cycle.
- Write: the array is updated at the edge sampling `validOut`. A read issued after the write completes returns the new data.
- Minimum IDLE→IDLE for a one-word write with `validOut` already high: 3 cycles.

## Configuration
- `MBUS_MEM_PARITY_CHECK_EN` defined:
  - On each write beat, `parOut` ≠ ~^`dOut` sets `error` (sticky until `reset`/`memReset`).
  - That word is not written; the sequence continues.
- Undefined: `parOut` is ignored and `error` is constant 0.
- `parIn` is generated in both cases.

## Test plan
- After reset, `startA`, `wrRq`, `adr`=0x10, `rq`=4'b1111, four `validOutA` beats with 1,2,3,4 → `acknA` at T+1; array[0x10..0x13]=1,2,3,4.
- `startB` read, `adr`=0x12, `rq`=4'b1011 → `acknB` at T+1; `validInB` at T+5,T+6,T+7 with `dIn`=3,4,1 (offsets 2,3,0); `parIn` odd; `acknA`/`validInA` stay 0.
- `startA` and `startB` high together → A acked first; B acked after A's cycle returns to IDLE.
- `adr` bit 14 set with ADDR_BITS=14 → no `ackn` for 20 cycles; state remains IDLE.
- RPW at `adr`=0x20 holding 7, `rq`=4'b1000 → `validIn` beat with 7, then write of 9 on `validOut`; a later read returns 9.
- With `MBUS_MEM_PARITY_CHECK_EN`, write beat with bad `parOut` → `error`=1, word unchanged; `memReset` clears `error`; a `memReset` mid-LAT → IDLE with no `validIn`.
